// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: shared state, error-code, selector and lane-geometry definitions for the PLL config controller
package pll_cfg_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_APPLY, S_WAIT, S_DONE, S_ERR} state_t;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ZERO = 2'b01;
  localparam logic [1:0] ERR_SEL = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
  localparam logic [2:0] SEL_OUT_MAX = 3'd4;
  localparam logic [2:0] SEL_IN = 3'd5;
  localparam int DIV_W = 10;
  localparam int PH_W = 13;
  localparam int N_LANES = 5;
endpackage

// File: rtl/pll_dyn_cfg_ctrl_lock_sync.sv
// pll_lock_sync: synchronizes pll_lock, qualifies it as stable, and flags falling edges of the qualified lock
module pll_lock_sync #(
  parameter int LOCK_STABLE = 8
) (
  input  logic clk_tb,
  input  logic rst_n,
  input  logic pll_lock,
  input  logic clr,
  output logic locked,
  output logic lock_fall
);
  localparam int SW = LOCK_STABLE > 1 ? $clog2(LOCK_STABLE) : 1;
  logic [1:0] sync;
  logic [SW-1:0] cnt;
  logic lk, locked_d;
  always_ff @(posedge clk_tb or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      cnt <= '0;
      lk <= 1'b0;
      locked_d <= 1'b0;
    end else begin
      sync <= {sync[0], pll_lock};
      locked_d <= locked;
      if (clr || !sync[1]) begin
        cnt <= '0;
        lk <= 1'b0;
      end else if (cnt == SW'(LOCK_STABLE - 1)) lk <= 1'b1;
      else cnt <= cnt + 1'b1;
    end
  // a low sample must drop locked in the same cycle, not one later
  assign locked = lk & sync[1];
  assign lock_fall = locked_d & ~locked;
endmodule

// File: rtl/pll_dyn_cfg_ctrl.sv
// pll_dyn_cfg_ctrl: validates one reconfiguration request at a time, drives the PLL dyn_* buses,
// pulses the matching reset, waits for stable lock and reports done/error; counts idle lock losses
module pll_dyn_cfg_ctrl
  import pll_cfg_pkg::*;
#(
  parameter int RST_CYCLES = 16,
  parameter int LOCK_STABLE = 8,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int DEF_IDIV = 2,
  parameter int DEF_FDIV = 32,
  parameter int DEF_ODIV = 100,
  parameter int DEF_DUTY = 100,
  parameter int DEF_PHASE = 16
) (
  input  logic clk_tb,
  input  logic rst_n,
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic [2:0] cfg_sel,
  input  logic [DIV_W-1:0] cfg_odiv,
  input  logic [DIV_W-1:0] cfg_duty,
  input  logic [PH_W-1:0] cfg_phase,
  output logic cfg_done,
  output logic cfg_err,
  output logic [1:0] err_code,
  output logic busy,
  input  logic pll_lock,
  output logic pll_rst,
  output logic rstodiv,
  output logic [DIV_W-1:0] dyn_idiv,
  output logic [DIV_W-1:0] dyn_fdiv,
  output logic [N_LANES*DIV_W-1:0] dyn_odiv,
  output logic [N_LANES*DIV_W-1:0] dyn_duty,
  output logic [N_LANES*PH_W-1:0] dyn_phase,
  output logic locked,
  output logic [7:0] lock_loss_cnt
);
  localparam int RW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
  localparam int TW = LOCK_TIMEOUT > 1 ? $clog2(LOCK_TIMEOUT) : 1;
  state_t state;
  logic [2:0] r_sel;
  logic [DIV_W-1:0] r_odiv, r_duty;
  logic [PH_W-1:0] r_phase;
  logic [RW-1:0] rcnt;
  logic [TW-1:0] tcnt;
  logic [1:0] chk_code;
  logic clr, lock_fall;
  // bad selector outranks a zero divider/duty
  assign chk_code = r_sel > SEL_IN ? ERR_SEL : (r_odiv == '0 || r_duty == '0) ? ERR_ZERO : ERR_NONE;
  assign clr = state == S_CHECK && chk_code == ERR_NONE;
  assign cfg_ready = state == S_IDLE;
  assign busy = ~cfg_ready;
  assign cfg_done = state == S_DONE;
  assign cfg_err = state == S_ERR;
  assign rstodiv = state == S_APPLY && r_sel != SEL_IN;
  assign pll_rst = state == S_APPLY && r_sel == SEL_IN;
  pll_lock_sync #(.LOCK_STABLE(LOCK_STABLE)) u_sync (
    .clk_tb(clk_tb),
    .rst_n(rst_n),
    .pll_lock(pll_lock),
    .clr(clr),
    .locked(locked),
    .lock_fall(lock_fall)
  );
  always_ff @(posedge clk_tb or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      r_sel <= '0;
      r_odiv <= '0;
      r_duty <= '0;
      r_phase <= '0;
      rcnt <= '0;
      tcnt <= '0;
      err_code <= ERR_NONE;
      dyn_idiv <= DIV_W'(DEF_IDIV);
      dyn_fdiv <= DIV_W'(DEF_FDIV);
      dyn_odiv <= {N_LANES{DIV_W'(DEF_ODIV)}};
      dyn_duty <= {N_LANES{DIV_W'(DEF_DUTY)}};
      dyn_phase <= {N_LANES{PH_W'(DEF_PHASE)}};
    end else
      case (state)
        S_IDLE:
          if (cfg_valid) begin
            r_sel <= cfg_sel;
            r_odiv <= cfg_odiv;
            r_duty <= cfg_duty;
            r_phase <= cfg_phase;
            err_code <= ERR_NONE;
            state <= S_CHECK;
          end
        S_CHECK:
          if (chk_code != ERR_NONE) begin
            err_code <= chk_code;
            state <= S_ERR;
          end else begin
            if (r_sel == SEL_IN) begin
              dyn_idiv <= r_odiv;
              dyn_fdiv <= r_duty;
            end else begin
              dyn_odiv[int'(r_sel)*DIV_W +: DIV_W] <= r_odiv;
              dyn_duty[int'(r_sel)*DIV_W +: DIV_W] <= r_duty;
              dyn_phase[int'(r_sel)*PH_W +: PH_W] <= r_phase;
            end
            rcnt <= '0;
            state <= S_APPLY;
          end
        S_APPLY:
          if (rcnt == RW'(RST_CYCLES - 1)) begin
            tcnt <= '0;
            state <= S_WAIT;
          end else rcnt <= rcnt + 1'b1;
        S_WAIT:
          if (locked) state <= S_DONE;
          else if (tcnt == TW'(LOCK_TIMEOUT - 1)) begin
            err_code <= ERR_TIMEOUT;
            state <= S_ERR;
          end else tcnt <= tcnt + 1'b1;
        default: state <= S_IDLE;
      endcase
  // lock drops outside IDLE are caused by our own reset pulses
  always_ff @(posedge clk_tb or negedge rst_n)
    if (!rst_n) lock_loss_cnt <= '0;
    else if (state == S_IDLE && lock_fall && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 1'b1;
endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// tb_pll_dyn_cfg_ctrl: directed requests against a behavioural PLL, checked every cycle by a
// timestamp-based transaction model plus hand-computed literal expectations
module tb_pll_dyn_cfg_ctrl;
  localparam int RST = 16, TO = 4096, RELOCK = 20;
  logic clk_tb = 0, rst_n = 0, cfg_valid = 0, pll_lock = 1;
  logic [2:0] cfg_sel = 0;
  logic [9:0] cfg_odiv = 0, cfg_duty = 0;
  logic [12:0] cfg_phase = 0;
  logic cfg_ready, cfg_done, cfg_err, busy, pll_rst, rstodiv, locked;
  logic [1:0] err_code;
  logic [9:0] dyn_idiv, dyn_fdiv;
  logic [49:0] dyn_odiv, dyn_duty;
  logic [64:0] dyn_phase;
  logic [7:0] lock_loss_cnt;
  pll_dyn_cfg_ctrl #(
    .RST_CYCLES(RST), .LOCK_STABLE(8), .LOCK_TIMEOUT(TO), .DEF_IDIV(2), .DEF_FDIV(32),
    .DEF_ODIV(100), .DEF_DUTY(100), .DEF_PHASE(16)
  ) dut (
    .clk_tb(clk_tb), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_odiv(cfg_odiv), .cfg_duty(cfg_duty), .cfg_phase(cfg_phase), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .err_code(err_code), .busy(busy), .pll_lock(pll_lock), .pll_rst(pll_rst),
    .rstodiv(rstodiv), .dyn_idiv(dyn_idiv), .dyn_fdiv(dyn_fdiv), .dyn_odiv(dyn_odiv),
    .dyn_duty(dyn_duty), .dyn_phase(dyn_phase), .locked(locked), .lock_loss_cnt(lock_loss_cnt)
  );
  always #5 clk_tb = ~clk_tb;
  int cyc = 0;
  always @(posedge clk_tb) cyc <= cyc + 1;
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  // behavioural PLL: lock lost while any reset is high, back RELOCK cycles after it falls
  int since = RELOCK;
  bit hold_low = 0, glitch = 0;
  always @(posedge clk_tb) begin
    #2;
    if (rstodiv || pll_rst) since = 0;
    else if (since < RELOCK) since++;
    pll_lock = !hold_low && !glitch && since >= RELOCK;
  end
  // transaction model: lock is stable once 9 consecutive raw samples (2-cycle sync delay) are high
  bit lock_at [0:16383];
  int last_clr, t0, m_end;
  bit m_busy, lk, l_prev, fin, win;
  logic [2:0] m_sel;
  logic [1:0] m_chk, m_res, m_code;
  logic [9:0] m_o, m_d, e_idiv, e_fdiv;
  logic [12:0] m_p;
  logic [49:0] e_odiv, e_duty;
  logic [64:0] e_phase;
  int e_cnt;
  function automatic bit lk_model(input int m);
    if (m < 10 || m - 8 < last_clr) return 0;
    for (int j = m - 10; j <= m - 2; j++) if (!lock_at[j]) return 0;
    return 1;
  endfunction
  task automatic model_reset();
    m_busy = 0; m_code = 0; e_cnt = 0; l_prev = 0; last_clr = -100; m_end = -1; t0 = -100; m_chk = 0; m_res = 0;
    e_idiv = 2; e_fdiv = 32; e_odiv = {5{10'd100}}; e_duty = {5{10'd100}}; e_phase = {5{13'd16}};
  endtask
  initial model_reset();
  always @(negedge clk_tb) begin
    lock_at[cyc] = rst_n && pll_lock;
    if (!rst_n) model_reset();
    lk = rst_n && lk_model(cyc);
    fin = m_busy && cyc == m_end;
    win = m_busy && m_chk == 0 && cyc >= t0 + 2 && cyc < t0 + 2 + RST;
    chk("ready", cfg_ready, !m_busy);
    chk("busy", busy, m_busy);
    chk("done", cfg_done, fin && m_res == 0);
    chk("err", cfg_err, fin && m_res != 0);
    chk("err_code", err_code, fin ? m_res : m_code);
    chk("rstodiv", rstodiv, win && m_sel != 5);
    chk("pll_rst", pll_rst, win && m_sel == 5);
    chk("idiv", dyn_idiv, e_idiv);
    chk("fdiv", dyn_fdiv, e_fdiv);
    chk("odiv", dyn_odiv, e_odiv);
    chk("duty", dyn_duty, e_duty);
    chk("phase", dyn_phase, e_phase);
    chk("locked", locked, lk);
    chk("lock_loss", lock_loss_cnt, e_cnt);
    if (rst_n) begin
      if (!m_busy) begin
        if (l_prev && !lk && e_cnt < 255) e_cnt++;
        if (cfg_valid) begin
          m_busy = 1; t0 = cyc; m_sel = cfg_sel; m_o = cfg_odiv; m_d = cfg_duty; m_p = cfg_phase; m_code = 0;
          m_chk = cfg_sel > 5 ? 2'b10 : (cfg_odiv == 0 || cfg_duty == 0) ? 2'b01 : 2'b00;
          m_res = m_chk;
          m_end = m_chk != 0 ? cyc + 2 : -1;
        end
      end else if (fin) begin
        m_busy = 0; m_code = m_res;
      end else if (m_chk == 0) begin
        if (cyc == t0 + 1) begin
          last_clr = t0 + 2;
          if (m_sel == 5) begin e_idiv = m_o; e_fdiv = m_d; end
          else begin
            e_odiv[m_sel*10 +: 10] = m_o; e_duty[m_sel*10 +: 10] = m_d; e_phase[m_sel*13 +: 13] = m_p;
          end
        end
        if (m_end < 0 && cyc >= t0 + 2 + RST) begin
          if (lk) begin m_end = cyc + 1; m_res = 0; end
          else if (cyc == t0 + 2 + RST + TO - 1) begin m_end = cyc + 1; m_res = 2'b11; end
        end
      end
      l_prev = lk;
    end
  end
  task automatic tick();
    @(posedge clk_tb); #1;
  endtask
  task automatic at(input int n);
    while (cyc < n) tick();
    @(negedge clk_tb);
  endtask
  task automatic req(input logic [2:0] s, input logic [9:0] o, input logic [9:0] d, input logic [12:0] p, output int t);
    tick();
    for (int i = 0; i < 5000 && !cfg_ready; i++) tick();
    chk("req_ready", cfg_ready, 1);
    cfg_valid = 1; cfg_sel = s; cfg_odiv = o; cfg_duty = d; cfg_phase = p; t = cyc;
    tick();
    cfg_valid = 0;
  endtask
  task automatic wait_locked();
    for (int i = 0; i < 300 && !locked; i++) tick();
    chk("lock_wait", locked, 1);
  endtask
  int a, b, c, d, g, h, e, f;
  initial begin
    @(negedge clk_tb);
    chk("rst_ready_lit", cfg_ready, 1);
    chk("rst_odiv_lit", dyn_odiv, {5{10'd100}});
    tick(); rst_n = 1;
    at(30);
    chk("init_locked_lit", locked, 1);
    req(3'd2, 10'd200, 10'd200, 13'd16, a);
    at(a + 1); chk("t1_busy_lit", busy, 1); chk("t1_lane2_old_lit", dyn_odiv[29:20], 100);
    at(a + 2); chk("t1_lane2_lit", dyn_odiv[29:20], 200); chk("t1_rst_on_lit", rstodiv, 1);
    chk("t1_others_lit", {dyn_odiv[49:30], dyn_odiv[19:0]}, {4{10'd100}});
    at(a + 17); chk("t1_rst_last_lit", rstodiv, 1);
    at(a + 18); chk("t1_rst_off_lit", rstodiv, 0);
    at(a + 47); chk("t1_done_early_lit", cfg_done, 0);
    at(a + 48); chk("t1_done_lit", cfg_done, 1); chk("t1_code_lit", err_code, 0);
    req(3'd5, 10'd4, 10'd64, 13'd0, b);
    at(b + 2); chk("t2_pllrst_lit", pll_rst, 1); chk("t2_idiv_lit", dyn_idiv, 4); chk("t2_fdiv_lit", dyn_fdiv, 64);
    at(b + 17); chk("t2_pllrst_last_lit", pll_rst, 1);
    at(b + 18); chk("t2_pllrst_off_lit", pll_rst, 0);
    at(b + 48); chk("t2_done_lit", cfg_done, 1);
    req(3'd1, 10'd0, 10'd50, 13'd3, c);
    at(c + 2); chk("t3_err_lit", cfg_err, 1); chk("t3_code_lit", err_code, 1); chk("t3_norst_lit", rstodiv, 0);
    chk("t3_lane1_lit", dyn_odiv[19:10], 100);
    at(c + 5); chk("t3_code_held_lit", err_code, 1);
    req(3'd7, 10'd0, 10'd0, 13'd0, d);
    at(d + 1); chk("t4_code_clr_lit", err_code, 0);
    at(d + 2); chk("t4_code_lit", err_code, 2); chk("t4_err_lit", cfg_err, 1);
    req(3'd5, 10'd9, 10'd0, 13'd0, g);
    at(g + 2); chk("t4b_code_lit", err_code, 1); chk("t4b_idiv_lit", dyn_idiv, 4);
    req(3'd0, 10'd1, 10'd1, 13'd0, h);
    at(h + 2); chk("t4c_odiv_lit", dyn_odiv[9:0], 1); chk("t4c_phase_lit", dyn_phase[12:0], 0);
    at(h + 48); chk("t4c_done_lit", cfg_done, 1);
    hold_low = 1;
    req(3'd4, 10'd20, 10'd10, 13'd7, e);
    at(e + RST + TO + 1); chk("t5_err_early_lit", cfg_err, 0);
    at(e + RST + TO + 2); chk("t5_err_lit", cfg_err, 1); chk("t5_code_lit", err_code, 3); chk("t5_locked_lit", locked, 0);
    hold_low = 0;
    for (int i = 0; i < 3; i++) begin
      wait_locked();
      glitch = 1;
      repeat (3) tick();
      glitch = 0;
    end
    wait_locked();
    at(cyc); chk("t6_llc_lit", lock_loss_cnt, 3);
    req(3'd3, 10'd50, 10'd50, 13'd5, f);
    at(f + 25);
    #2 rst_n = 0;
    #1;
    chk("t7_ready_lit", cfg_ready, 1); chk("t7_rstodiv_lit", rstodiv, 0); chk("t7_odiv_lit", dyn_odiv, {5{10'd100}});
    chk("t7_llc_lit", lock_loss_cnt, 0); chk("t7_locked_lit", locked, 0);
    repeat (2) @(posedge clk_tb);
    #1 rst_n = 1;
    repeat (60) tick();
    at(cyc); chk("t7_relock_lit", locked, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pll_dyn_cfg_ctrl.md
Name: pll_dyn_cfg_ctrl

Overview:
- Initiator side of the PLL dynamic-reconfiguration interface.
- Accepts one reconfiguration request at a time over a valid/ready port.
- For each request it range-checks the values, drives the PLL dyn_* divider/duty/phase buses and sequences pll_rst or rstodiv.
- It then waits for a stable pll_lock and reports done or error with a code. It also counts unexpected lock losses while idle.
- Sits between system control logic and the pll instance, replacing hand-driven dyn_* stimulus.

Parameters:
- RST_CYCLES, 16, cycles pll_rst/rstodiv is held high per request (min 1).
- LOCK_STABLE, 8, consecutive synchronized lock-high cycles needed to declare lock.
- LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK before timeout error.
- DEF_IDIV, 2, reset value of dyn_idiv.
- DEF_FDIV, 32, reset value of dyn_fdiv.
- DEF_ODIV, 100, reset value of every dyn_odiv lane.
- DEF_DUTY, 100, reset value of every dyn_duty lane.
- DEF_PHASE, 16, reset value of every dyn_phase lane.

Ports:
- clk_tb  in  1  controller clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  request valid.
- cfg_ready  out  1  high only in IDLE.
- cfg_sel  in  3  0-4 = output channel, 5 = input/feedback dividers, 6-7 illegal.
- cfg_odiv  in  10  odiv for sel 0-4; idiv for sel 5.
- cfg_duty  in  10  duty for sel 0-4; fdiv for sel 5.
- cfg_phase  in  13  phase for sel 0-4; ignored for sel 5.
- cfg_done  out  1  one-cycle success pulse.
- cfg_err  out  1  one-cycle failure pulse.
- err_code  out  2  01 zero value, 10 bad sel, 11 lock timeout; held until next request.
- busy  out  1  equal to ~cfg_ready.
- pll_lock  in  1  asynchronous lock from PLL.
- pll_rst  out  1  PLL reset, used for sel 5.
- rstodiv  out  1  output-divider reset, used for sel 0-4.
- dyn_idiv  out  10  input divider.
- dyn_fdiv  out  10  feedback divider.
- dyn_odiv  out  50  lane n = bits [10n+9:10n].
- dyn_duty  out  50  lane n = bits [10n+9:10n].
- dyn_phase  out  65  lane n = bits [13n+12:13n].
- locked  out  1  synchronized, stable lock.
- lock_loss_cnt  out  8  saturating count of unexpected lock drops.

Behaviour:
- Reset values: dyn_* take their DEF_* values. All other outputs are 0, except cfg_ready = 1.
- pll_lock passes through a 2-flop synchronizer. A stable counter then sets `locked` after LOCK_STABLE consecutive high samples. Any low sample clears the counter and `locked` in the same cycle.
- FSM states: IDLE, CHECK, APPLY, WAIT_LOCK, DONE, ERR.
- IDLE:
  - The handshake fires on cfg_valid && cfg_ready (cycle 0) and the request is captured.
  - Goes to CHECK.
  - cfg_valid without ready is ignored; the requester must hold it.
- CHECK (cycle 1): detect errors.
  - sel 6/7 gives code 10.
  - Any zero in odiv/duty (sel 0-4) or idiv/fdiv (sel 5) gives code 01.
  - Bad sel takes priority over a zero value.
  - On error go to ERR with dyn_* unchanged. Otherwise go to APPLY.
- APPLY (entered at cycle 2):
  - The selected lane of dyn_* (or idiv/fdiv) updates at cycle 2. Other lanes are untouched.
  - rstodiv (sel 0-4) or pll_rst (sel 5) is high for exactly RST_CYCLES cycles, starting at cycle 2. Then go to WAIT_LOCK.
  - The stable counter is cleared on entry to APPLY.
- WAIT_LOCK:
  - The timeout counter starts at 0.
  - If `locked` is high, go to DONE.
  - If the counter reaches LOCK_TIMEOUT-1 without lock, go to ERR with code 11.
  - Lock glitches restart the stable counter but not the timeout counter.
- DONE/ERR: one cycle. Pulse cfg_done or cfg_err, then return to IDLE. cfg_done leaves err_code at 00.
- Lock-loss monitor:
  - Counts only in IDLE, on a 1->0 transition of `locked`.
  - lock_loss_cnt saturates at 255.
  - Drops during APPLY/WAIT_LOCK are expected and not counted.
- Async reset mid-sequence: all state, counters and dyn_* return to reset values immediately. pll_rst/rstodiv drop to 0.
- Counter widths are $clog2 of the matching parameter.

Decomposition:
- Package pll_cfg_pkg holds:
  - FSM state enum.
  - err_code constants (ERR_NONE/ZERO/SEL/TIMEOUT).
  - sel constants (SEL_OUT_MAX = 4, SEL_IN = 5).
  - lane widths (10, 13) and lane count 5.
- One sub-module, pll_lock_sync, contains:
  - the 2-flop synchronizer;
  - the LOCK_STABLE counter producing `locked`;
  - falling-edge detect of `locked`.

Test Plan:
- Reset, then sel=2, odiv=200, duty=200, phase=16; behavioural PLL re-locks 20 cycles after rstodiv falls.
  - Required: dyn_odiv[29:20]=200 at cycle 2; rstodiv high cycles 2-17; cfg_done one cycle; all other lanes stay 100.
- sel=5, idiv=4, fdiv=64.
  - Required: pll_rst high 16 cycles; dyn_idiv=4, dyn_fdiv=64; cfg_done after lock is stable for 8 cycles.
- sel=1 with odiv=0.
  - Required: cfg_err at cycle 2, err_code=01, no reset pulse, dyn_* unchanged.
- sel=7.
  - Required: err_code=10.
- pll_lock held low.
  - Required: cfg_err with code 11 exactly RST_CYCLES+LOCK_TIMEOUT cycles after APPLY entry; locked=0.
- In IDLE with locked=1, drop pll_lock three times.
  - Required: lock_loss_cnt=3.
- Assert rst_n mid-WAIT_LOCK.
  - Required: all outputs return to reset values, cfg_ready=1.
